// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
//   NUM_REGS / REG_ADDR_W : register file geometry
//   REQ_ALU / REQ_MEM     : requester indices into the grant vector
package regfile_wb_arbiter_pkg;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REQ    = 2;
    localparam int REQ_ALU    = 0;
    localparam int REQ_MEM    = 1;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, issue logic and the register file.
//   req0_* / req1_* : valid/ready write-back requests (rd, data)
//   rsv_*           : destination reservation from issue logic
//   RegWrite/W1/WD1 : registered register file write port controls
// Modports: arb (the arbiter side), src (requesters/issue/register file side).
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int Width = 32
);
    logic             req0_valid;
    reg_addr_t        req0_rd;
    logic [Width-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    reg_addr_t        req1_rd;
    logic [Width-1:0] req1_data;
    logic             req1_ready;
    logic             rsv_valid;
    reg_addr_t        rsv_rd;
    logic             RegWrite;
    reg_addr_t        W1;
    logic [Width-1:0] WD1;

    modport arb (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
               rsv_valid, rsv_rd,
        output req0_ready, req1_ready, RegWrite, W1, WD1
    );

    modport src (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
               rsv_valid, rsv_rd,
        input  req0_ready, req1_ready, RegWrite, W1, WD1
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
//   clk, rst  : clock, async active-high reset
//   valid_i   : request vector
//   advance_i : a transfer happened this cycle; move the pointer
//   grant_o   : one-hot grant (combinational)
// last_q holds the most recently granted index; it resets to 1 so that
// requester 0 wins the first contention.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);
    logic last_q, last_d;

    always_comb begin
        grant_o = valid_i;
        // Contention: the side not granted most recently wins.
        if (&valid_i) grant_o = last_q ? 2'b01 : 2'b10;
    end

    always_comb begin
        last_d = last_q;
        if (advance_i) last_d = grant_o[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 32-entry register file.
//   clk, rst : clock, async active-high reset
//   bus      : write-back interface (arb modport): requests, reservation,
//              registered RegWrite/W1/WD1
//   busy     : per-register outstanding-write scoreboard (bit 0 always 0)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.arb   bus,
    output logic [NUM_REGS-1:0] busy
);
    logic [NUM_REQ-1:0]                 req_valid, grant;
    logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_rd;
    logic [NUM_REQ-1:0][Width-1:0]      req_data;
    logic                               xfer;
    reg_addr_t                          rd_sel;
    logic [Width-1:0]                   data_sel;

    logic                RegWrite_q;
    reg_addr_t           W1_q;
    logic [Width-1:0]    WD1_q;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    assign req_valid[REQ_ALU] = bus.req0_valid;
    assign req_valid[REQ_MEM] = bus.req1_valid;
    assign req_rd[REQ_ALU]    = bus.req0_rd;
    assign req_rd[REQ_MEM]    = bus.req1_rd;
    assign req_data[REQ_ALU]  = bus.req0_data;
    assign req_data[REQ_MEM]  = bus.req1_data;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (req_valid),
        .advance_i (xfer),
        .grant_o   (grant)
    );

    // Grant is only ever given to a valid requester, so any grant is a transfer.
    assign xfer           = |grant;
    assign bus.req0_ready = grant[REQ_ALU];
    assign bus.req1_ready = grant[REQ_MEM];
    assign rd_sel         = grant[REQ_MEM] ? req_rd[REQ_MEM]   : req_rd[REQ_ALU];
    assign data_sel       = grant[REQ_MEM] ? req_data[REQ_MEM] : req_data[REQ_ALU];

    // x0 writes complete the handshake but never assert the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite_q <= 1'b0;
            W1_q       <= '0;
            WD1_q      <= '0;
        end else begin
            RegWrite_q <= xfer && (rd_sel != '0);
            if (xfer) begin
                W1_q  <= rd_sel;
                WD1_q <= data_sel;
            end
        end
    end

    // Clear on the commit edge, then apply a new reservation so that it
    // supersedes a completing write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (RegWrite_q) busy_d[W1_q] = 1'b0;
        if (bus.rsv_valid && bus.rsv_rd != '0) busy_d[bus.rsv_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign bus.RegWrite = RegWrite_q;
    assign bus.W1       = W1_q;
    assign bus.WD1      = WD1_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter plus hand-written
// sequences for asynchronous reset and pointer reset.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] busy;
    int          ncmp = 0;
    int          nerr = 0;

    regfile_wb_arbiter_if #(.Width(32)) bus ();

    regfile_wb_arbiter #(.Width(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic        rv;
        logic [4:0]  rr;
        logic        er0;
        logic        er1;
        logic        erw;
        logic [4:0]  ew1;
        logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic v0, logic [4:0] rd0, logic [31:0] d0,
                                logic v1, logic [4:0] rd1, logic [31:0] d1,
                                logic rv, logic [4:0] rr,
                                logic er0, logic er1, logic erw,
                                logic [4:0] ew1, logic [31:0] ewd, logic [31:0] ebusy);
        vec_t v;
        v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
        v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
        v.rv = rv; v.rr = rr;
        v.er0 = er0; v.er1 = er1; v.erw = erw;
        v.ew1 = ew1; v.ewd = ewd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.req0_valid = v.v0; bus.req0_rd = v.rd0; bus.req0_data = v.d0;
        bus.req1_valid = v.v1; bus.req1_rd = v.rd1; bus.req1_data = v.d1;
        bus.rsv_valid  = v.rv; bus.rsv_rd  = v.rr;
    endtask

    task automatic idle();
        drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0));
    endtask

    initial begin
        // Fields: req0 v/rd/data, req1 v/rd/data, rsv v/rd |
        //         expected ready0, ready1 (before edge), RegWrite, W1, WD1, busy (after edge)
        tbl[0]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0);
        tbl[1]  = mk(1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,   1'b0, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       32'h0);
        tbl[2]  = mk(1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,   1'b0, 5'd0,
                     1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       32'h0);
        tbl[3]  = mk(1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,   1'b0, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd3, 32'h33,       32'h0);
        tbl[4]  = mk(1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,   1'b0, 5'd0,
                     1'b0, 1'b1, 1'b1, 5'd4, 32'h44,       32'h0);
        tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd4, 32'h44,       32'h0);
        tbl[6]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
        tbl[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9,
                     1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h200);
        tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h1234, 1'b0, 5'd0,
                     1'b0, 1'b1, 1'b0, 5'd0, 32'h1234,     32'h200);
        tbl[9]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'h1234,     32'h280);
        tbl[10] = mk(1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 32'h0,    1'b0, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd7, 32'h77,       32'h280);
        tbl[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7,
                     1'b0, 1'b0, 1'b0, 5'd7, 32'h77,       32'h280);
        tbl[12] = mk(1'b1, 5'd7, 32'h78,       1'b0, 5'd0, 32'h0,    1'b0, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd7, 32'h78,       32'h280);
        tbl[13] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd7, 32'h78,       32'h200);
        tbl[14] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,   1'b0, 5'd0,
                     1'b0, 1'b1, 1'b1, 5'd9, 32'h99,       32'h200);
        tbl[15] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd9, 32'h99,       32'h0);

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("reset W1",       {27'd0, bus.W1},       32'd0);
        chk("reset WD1",      bus.WD1,               32'd0);
        chk("reset busy",     busy,                  32'd0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d req0_ready", i), {31'd0, bus.req0_ready}, {31'd0, tbl[i].er0});
            chk($sformatf("v%0d req1_ready", i), {31'd0, bus.req1_ready}, {31'd0, tbl[i].er1});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d RegWrite", i), {31'd0, bus.RegWrite}, {31'd0, tbl[i].erw});
            chk($sformatf("v%0d W1", i),       {27'd0, bus.W1},       {27'd0, tbl[i].ew1});
            chk($sformatf("v%0d WD1", i),      bus.WD1,               tbl[i].ewd);
            chk($sformatf("v%0d busy", i),     busy,                  tbl[i].ebusy);
        end

        // Accepted write to x12 with a reservation, then async reset before commit.
        drive(mk(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0));
        @(posedge clk);
        #1;
        chk("pre-reset RegWrite", {31'd0, bus.RegWrite}, 32'd1);
        chk("pre-reset busy",     busy,                  32'h1000);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("async RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        chk("async W1",       {27'd0, bus.W1},       32'd0);
        chk("async WD1",      bus.WD1,               32'd0);
        chk("async busy",     busy,                  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pointer was 0 before reset; after reset requester 0 must win again.
        drive(mk(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0,
                 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0));
        #1;
        chk("post-reset req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        chk("post-reset req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("post-reset W1",  {27'd0, bus.W1}, 32'd1);
        chk("post-reset WD1", bus.WD1,         32'h11);
        idle();
        @(posedge clk);
        #1;
        chk("post-reset idle RegWrite", {31'd0, bus.RegWrite}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32-entry integer register file. It shares the register file's single write port between two write-back requesters, requester 0 (ALU path) and requester 1 (load/long-latency path), using round-robin arbitration and a valid/ready handshake. It drives the register file write controls from registered outputs. It also keeps a per-register busy scoreboard that issue logic sets on dispatch and that clears when the matching write commits, so hazard logic can stall on pending destinations.

## Interface
Parameters:
- Width, 32, data width of write-back data and register file entries

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a write-back pending
- req0_rd  in  5  requester 0 destination register
- req0_data  in  Width  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid, req1_rd, req1_data, req1_ready  same as requester 0, for requester 1
- rsv_valid  in  1  issue logic reserves a destination this cycle
- rsv_rd  in  5  destination register being reserved
- RegWrite  out  1  register file write enable (registered)
- W1  out  5  register file write address (registered)
- WD1  out  Width  register file write data (registered)
- busy  out  32  scoreboard; bit i set means register i has a write outstanding

## Operation
- Grant (combinational):
  - Exactly one valid requester: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - Neither valid: no grant.
  - Grant is independent of rd; two requests to the same rd are serialized, not merged.
- Handshake:
  - reqN_ready equals grantN. A transfer occurs when valid && ready.
  - At most one ready is high per cycle.
  - A requester must hold rd and data stable while valid and not ready.
- Round-robin pointer `last`:
  - 1 bit; updated to the granted index on every transfer.
  - Reset value 1, so requester 0 wins the first contention.
- Output register:
  - On a transfer, W1 and WD1 load the granted rd and data at the edge.
  - RegWrite loads 1 unless rd == 0. For a write to x0 the transfer completes, but RegWrite loads 0; W1 and WD1 still load.
  - With no transfer, RegWrite loads 0 and W1/WD1 hold their values.
- Scoreboard:
  - busy[rsv_rd] is set at the edge when rsv_valid && rsv_rd != 0.
  - busy[W1] is cleared at the edge when RegWrite is high. This is the same edge at which the register file captures the data.
  - If a set and a clear target the same register at the same edge, the set wins (a new reservation supersedes the completing write).
  - busy[0] is constant 0.
  - A clear with busy already 0 is legal and has no effect.
- Reset (asynchronous):
  - RegWrite = 0, W1 = 0, WD1 = 0, busy = 0, last = 1.
  - A reset that arrives between a transfer and its commit discards that write; no register file write occurs.

## Timing
- Request accepted at edge N; RegWrite/W1/WD1 are valid during cycle N..N+1; the register file is written at edge N+1.
- Write-back latency: 1 cycle from acceptance to the outputs, 2 edges from acceptance to register file update.
- Throughput: one write per cycle. Under continuous contention, each requester is granted every other cycle.
- Scoreboard set is visible on busy one cycle after rsv_valid.
- busy clears in the same cycle that the register file content becomes readable. There is no window in which busy = 0 and the data is stale.
- No combinational path from rsv_* to busy, or from any input to RegWrite/W1/WD1.

## Structure
- Shared package/header: constants NUM_REGS = 32, REG_ADDR_W = 5, and requester indices REQ_ALU = 0 and REQ_MEM = 1.
- One sub-module: rr_arbiter2, a 2-way round-robin grant with its `last` pointer. Inputs: valid[1:0] and an advance strobe. Output: one-hot grant[1:0].
- The top level holds the output register and the scoreboard.

## Test plan
- Reset, then idle: RegWrite = 0, W1 = 0, WD1 = 0, busy = 0; asserting rst mid-cycle clears the outputs immediately, without waiting for clk.
- req0 alone, rd = 5, data 0xDEADBEEF: req0_ready = 1; in the next cycle RegWrite = 1, W1 = 5, WD1 = 0xDEADBEEF; next cycle RegWrite = 0.
- Both valid for 4 cycles (rd 3 and rd 4): grants alternate 0, 1, 0, 1; the output W1 sequence is 3, 4, 3, 4.
- req1 writes rd = 0, data 0x1234: req1_ready = 1, next-cycle RegWrite = 0, busy unchanged.
- rsv rd = 7, then req0 writes rd = 7: busy[7] = 1 the cycle after rsv; it clears at the edge where RegWrite = 1 with W1 = 7.
- At that same edge, assert rsv rd = 7 again: busy[7] stays 1. A simultaneous rsv of rd = 0 leaves busy[0] = 0.
